rng_seed_sequencer: RTL and testbench

Parametrised seed-index sequencer for the RNG datapath. It holds a writable table of NUM_SEEDS seeds and, once started, presents one seed every DIV+1 cycles on a valid/ready handshake. The next table index is chosen per mode: increment, decrement, LFSR-scrambled or hold. It sits between the control interface and the RNG core's seed-load port. It replaces the free-running 2-bit seed selector.

---
 rtl/rng_seed_sequencer.sv | 138 +++++++++++++
 tb/tb_rng_seed_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_seed_sequencer.sv
// Seed-index sequencer: walks a writable seed table and offers one seed every
// DIV+1 cycles to the RNG core over a valid/ready handshake.
module rng_seed_sequencer #(
    parameter int NUM_SEEDS = 4,
    parameter int SEL_W     = 2,
    parameter int SEED_W    = 16,
    parameter int DIV       = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              one_shot_i,
    input  logic [1:0]        mode_i,
    input  logic              wr_en_i,
    input  logic [SEL_W-1:0]  wr_addr_i,
    input  logic [SEED_W-1:0] wr_data_i,
    output logic [SEED_W-1:0] seed_o,
    output logic              seed_valid_o,
    input  logic              seed_ready_i,
    output logic [SEL_W-1:0]  seed_sel_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_e;

    localparam logic [SEL_W:0]   NUM_W    = (SEL_W+1)'(NUM_SEEDS);
    localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(NUM_SEEDS - 1);
    localparam logic [15:0]      CNT_LAST = 16'(DIV - 1);
    localparam int               LW       = (SEL_W < 8) ? SEL_W : 8;

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    logic                valid_q, valid_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                stop_pend_q, stop_pend_d;
    logic                one_shot_q, one_shot_d;
    logic [7:0]          lfsr_q, lfsr_d;
    logic [SEED_W-1:0]   table_q [NUM_SEEDS];
    logic [SEED_W-1:0]   table_d [NUM_SEEDS];
    logic [SEL_W-1:0]    lfsr_raw, lfsr_idx, next_sel;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            seed_q      <= '0;
            valid_q     <= 1'b0;
            sel_q       <= '0;
            stop_pend_q <= 1'b0;
            one_shot_q  <= 1'b0;
            lfsr_q      <= 8'hA5;
            for (int k = 0; k < NUM_SEEDS; k++) table_q[k] <= SEED_W'(k + 1);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            valid_q     <= valid_d;
            sel_q       <= sel_d;
            stop_pend_q <= stop_pend_d;
            one_shot_q  <= one_shot_d;
            lfsr_q      <= lfsr_d;
            table_q     <= table_d;
        end
    end

    // Free-running scrambler; its low bits folded into range give the LFSR-mode index.
    always_comb begin
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        lfsr_raw = SEL_W'(lfsr_q[LW-1:0]);
        lfsr_idx = ({1'b0, lfsr_raw} >= NUM_W) ? lfsr_raw - NUM_W[SEL_W-1:0] : lfsr_raw;
        case (mode_i)
            2'b00:   next_sel = (sel_q == MAX_SEL) ? '0 : sel_q + 1'b1;
            2'b01:   next_sel = (sel_q == '0) ? MAX_SEL : sel_q - 1'b1;
            2'b10:   next_sel = lfsr_idx;
            default: next_sel = sel_q;
        endcase
    end

    always_comb begin
        table_d = table_q;
        if (wr_en_i && ({1'b0, wr_addr_i} < NUM_W)) table_d[wr_addr_i] = wr_data_i;
    end

    // Handshake: once seed_valid_o rises, seed_o is frozen until a cycle with
    // seed_valid_o && seed_ready_i; only that cycle transfers a seed.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seed_d      = seed_q;
        valid_d     = valid_q;
        sel_d       = sel_q;
        stop_pend_d = stop_pend_q;
        one_shot_d  = one_shot_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    one_shot_d = one_shot_i;
                    cnt_d      = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 16'd1;
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    seed_d  = table_q[sel_q];
                    valid_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (valid_q && seed_ready_i) begin
                    valid_d = 1'b0;
                    sel_d   = next_sel;
                    if (stop_pend_q || one_shot_q || stop_i) begin
                        stop_pend_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end
                end else if (stop_i) begin
                    stop_pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign seed_o       = seed_q;
    assign seed_valid_o = valid_q;
    assign seed_sel_o   = sel_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rng_seed_sequencer.sv
// Directed bench: one 4-entry instance and one 3-entry instance share stimulus.
module tb_rng_seed_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, stop = 1'b0, one_shot = 1'b0, ready = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;

    logic [15:0] seed4, seed3;
    logic        valid4, valid3, busy4, busy3;
    logic [1:0]  sel4, sel3;
    logic [7:0]  lfsr_m;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rng_seed_sequencer #(.NUM_SEEDS(4), .SEL_W(2), .SEED_W(16), .DIV(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .one_shot_i(one_shot),
        .mode_i(mode), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .seed_o(seed4), .seed_valid_o(valid4), .seed_ready_i(ready),
        .seed_sel_o(sel4), .busy_o(busy4)
    );

    rng_seed_sequencer #(.NUM_SEEDS(3), .SEL_W(2), .SEED_W(16), .DIV(4)) dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .one_shot_i(one_shot),
        .mode_i(mode), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .seed_o(seed3), .seed_valid_o(valid3), .seed_ready_i(ready),
        .seed_sel_o(sel3), .busy_o(busy3)
    );

    // Reference scrambler, x^8+x^6+x^5+x^4+1 from 8'hA5.
    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 8'hA5;
        else      lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b0; stop = 1'b0; one_shot = 1'b0; ready = 1'b0;
        mode = 2'b00; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pulse_start(input logic os);
        @(negedge clk);
        start = 1'b1; one_shot = os;
        @(negedge clk);
        start = 1'b0; one_shot = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!valid4 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (seed4 !== 16'h0) begin n_bad++; $display("FAIL reset_seed got %h want 0000", seed4); end
        n_cmp++; if (valid4 !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid4); end
        n_cmp++; if (sel4 !== 2'd0) begin n_bad++; $display("FAIL reset_sel got %0d want 0", sel4); end
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy4); end
    endtask

    task automatic test_inc();
        int n;
        do_reset();
        mode = 2'b00; ready = 1'b1;
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            wait_valid(n);
            n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL inc_latency[%0d] got %0d want 5", i, n); end
            n_cmp++; if (seed4 !== 16'(i % 4 + 1)) begin n_bad++; $display("FAIL inc_seed4[%0d] got %h want %h", i, seed4, i % 4 + 1); end
            n_cmp++; if (sel4 !== 2'(i % 4)) begin n_bad++; $display("FAIL inc_sel4[%0d] got %0d want %0d", i, sel4, i % 4); end
            n_cmp++; if (seed3 !== 16'(i % 3 + 1)) begin n_bad++; $display("FAIL inc_seed3[%0d] got %h want %h", i, seed3, i % 3 + 1); end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL inc_stop_busy got %b want 0", busy4); end
        n_cmp++; if (sel4 !== 2'd1) begin n_bad++; $display("FAIL inc_stop_sel got %0d want 1", sel4); end
    endtask

    task automatic test_dec();
        int n;
        logic [15:0] exp_seed [4];
        logic [1:0]  exp_sel [4];
        exp_seed = '{16'd1, 16'd4, 16'd3, 16'd2};
        exp_sel  = '{2'd0, 2'd3, 2'd2, 2'd1};
        do_reset();
        mode = 2'b01; ready = 1'b1;
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            wait_valid(n);
            n_cmp++; if (seed4 !== exp_seed[i]) begin n_bad++; $display("FAIL dec_seed[%0d] got %h want %h", i, seed4, exp_seed[i]); end
            n_cmp++; if (sel4 !== exp_sel[i]) begin n_bad++; $display("FAIL dec_sel[%0d] got %0d want %0d", i, sel4, exp_sel[i]); end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_stall_stop();
        int n;
        do_reset();
        mode = 2'b00; ready = 1'b0;
        pulse_start(1'b0);
        wait_valid(n);
        n_cmp++; if (seed4 !== 16'd1) begin n_bad++; $display("FAIL stall_first_seed got %h want 0001", seed4); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            stop = (c == 2);
            n_cmp++; if (valid4 !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got %b want 1", c, valid4); end
            n_cmp++; if (seed4 !== 16'd1) begin n_bad++; $display("FAIL stall_seed[%0d] got %h want 0001", c, seed4); end
        end
        stop = 1'b0; ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (valid4 !== 1'b0) begin n_bad++; $display("FAIL stall_accept_valid got %b want 0", valid4); end
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL stall_idle_busy got %b want 0", busy4); end
        n_cmp++; if (sel4 !== 2'd1) begin n_bad++; $display("FAIL stall_sel got %0d want 1", sel4); end
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (valid4) n++;
        end
        n_cmp++; if (n !== 0) begin n_bad++; $display("FAIL stall_extra_issue got %0d valid cycles want 0", n); end
    endtask

    task automatic test_stop_run();
        do_reset();
        mode = 2'b00; ready = 1'b1;
        pulse_start(1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL run_stop_busy got %b want 0", busy4); end
        n_cmp++; if (sel4 !== 2'd0) begin n_bad++; $display("FAIL run_stop_sel got %0d want 0", sel4); end
        repeat (6) @(negedge clk);
        n_cmp++; if (valid4 !== 1'b0) begin n_bad++; $display("FAIL run_stop_valid got %b want 0", valid4); end
    endtask

    task automatic test_write_presented();
        int n;
        logic [15:0] exp_seed [4];
        exp_seed = '{16'd4, 16'd1, 16'd2, 16'hBEEF};
        do_reset();
        mode = 2'b00; ready = 1'b1;
        pulse_start(1'b0);
        wait_valid(n);
        @(negedge clk); wait_valid(n);
        @(negedge clk); wait_valid(n);
        ready = 1'b0;
        n_cmp++; if (sel4 !== 2'd2) begin n_bad++; $display("FAIL wr_pres_sel got %0d want 2", sel4); end
        write_entry(2'd2, 16'hBEEF);
        n_cmp++; if (seed4 !== 16'd3) begin n_bad++; $display("FAIL wr_pres_held got %h want 0003", seed4); end
        @(negedge clk);
        n_cmp++; if (seed4 !== 16'd3) begin n_bad++; $display("FAIL wr_pres_held2 got %h want 0003", seed4); end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wait_valid(n);
            n_cmp++; if (seed4 !== exp_seed[i]) begin n_bad++; $display("FAIL wr_pres_seed[%0d] got %h want %h", i, seed4, exp_seed[i]); end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_write_ignored();
        int n;
        logic [15:0] exp3 [4];
        logic [15:0] exp4 [4];
        exp3 = '{16'd1, 16'd2, 16'd3, 16'd1};
        exp4 = '{16'd1, 16'd2, 16'd3, 16'hDEAD};
        do_reset();
        write_entry(2'd3, 16'hDEAD);
        mode = 2'b00; ready = 1'b1;
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            wait_valid(n);
            n_cmp++; if (seed3 !== exp3[i]) begin n_bad++; $display("FAIL wr_ign_seed3[%0d] got %h want %h", i, seed3, exp3[i]); end
            n_cmp++; if (seed4 !== exp4[i]) begin n_bad++; $display("FAIL wr_ign_seed4[%0d] got %h want %h", i, seed4, exp4[i]); end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_lfsr();
        int n;
        logic [1:0] exp_sel;
        logic [1:0] r;
        do_reset();
        mode = 2'b10; ready = 1'b1;
        exp_sel = 2'd0;
        pulse_start(1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            wait_valid(n);
            n_cmp++; if (valid3 !== 1'b1) begin n_bad++; $display("FAIL lfsr_valid[%0d] got %b want 1", i, valid3); end
            n_cmp++; if (sel3 > 2'd2) begin n_bad++; $display("FAIL lfsr_range[%0d] got %0d want <=2", i, sel3); end
            n_cmp++; if (sel3 !== exp_sel) begin n_bad++; $display("FAIL lfsr_sel[%0d] got %0d want %0d", i, sel3, exp_sel); end
            n_cmp++; if (seed3 !== 16'(exp_sel) + 16'd1) begin n_bad++; $display("FAIL lfsr_seed[%0d] got %h want %h", i, seed3, exp_sel + 1); end
            r = lfsr_m[1:0];
            exp_sel = (r == 2'd3) ? 2'd0 : r;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_cmp++; if (sel3 !== exp_sel) begin n_bad++; $display("FAIL lfsr_last_sel got %0d want %0d", sel3, exp_sel); end
    endtask

    task automatic test_one_shot();
        int n;
        do_reset();
        mode = 2'b00; ready = 1'b1;
        pulse_start(1'b1);
        wait_valid(n);
        n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL oneshot_latency got %0d want 5", n); end
        n_cmp++; if (seed4 !== 16'd1) begin n_bad++; $display("FAIL oneshot_seed got %h want 0001", seed4); end
        @(negedge clk);
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL oneshot_busy got %b want 0", busy4); end
        n_cmp++; if (sel4 !== 2'd1) begin n_bad++; $display("FAIL oneshot_sel got %0d want 1", sel4); end
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (valid4) n++;
        end
        n_cmp++; if (n !== 0) begin n_bad++; $display("FAIL oneshot_extra got %0d valid cycles want 0", n); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        write_entry(2'd0, 16'h1234);
        mode = 2'b00; ready = 1'b0;
        pulse_start(1'b0);
        wait_valid(n);
        n_cmp++; if (seed4 !== 16'h1234) begin n_bad++; $display("FAIL rstmid_written got %h want 1234", seed4); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (valid4 !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", valid4); end
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy4); end
        @(negedge clk);
        rst = 1'b1; ready = 1'b1;
        pulse_start(1'b1);
        wait_valid(n);
        n_cmp++; if (seed4 !== 16'd1) begin n_bad++; $display("FAIL rstmid_table got %h want 0001", seed4); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_inc();
        test_dec();
        test_stall_stop();
        test_stop_run();
        test_write_presented();
        test_write_ignored();
        test_lfsr();
        test_one_shot();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
